// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes, framing states and
// the mid-bit sample index.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone,
    StBreakWait
  } uart_state_e;

  function automatic int unsigned mid_bit(input int unsigned clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receive-side result bundle: the receiver drives it (master), the loader consumes it (slave).
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 o_Rx_DV;
  logic [DATA_BITS-1:0] o_Rx_Byte;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Break;
  logic                 o_Rx_Busy;

  modport master (
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Parity_Err,
    output o_Frame_Err,
    output o_Break,
    output o_Rx_Busy
  );

  modport slave (
    input o_Rx_DV,
    input o_Rx_Byte,
    input o_Parity_Err,
    input o_Frame_Err,
    input o_Break,
    input o_Rx_Busy
  );
endinterface

// File: rtl/uart_bit_sampler.sv
// Input synchroniser, per-bit counter and 3-sample majority vote around mid-bit.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_serial,
  input  logic clear,
  output logic line,
  output logic sample_valid,
  output logic vote,
  output logic bit_end
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned Mid  = mid_bit(CLKS_PER_BIT);

  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntEarly = CntW'(Mid - 1);
  localparam logic [CntW-1:0] CntMid   = CntW'(Mid);
  localparam logic [CntW-1:0] CntLate  = CntW'(Mid + 1);

  logic            meta_q, line_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            early_q, mid_q;

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      line_q <= 1'b1;
    end else begin
      meta_q <= rx_serial;
      line_q <= meta_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || (cnt_q == CntLast)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      early_q <= 1'b1;
      mid_q   <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      if (cnt_q == CntEarly) early_q <= line_q;
      if (cnt_q == CntMid)   mid_q   <= line_q;
    end
  end

  // Third sample is the live line, so the vote is ready in the MID+1 cycle itself.
  assign line         = line_q;
  assign sample_valid = (cnt_q == CntLate);
  assign vote         = (early_q & mid_q) | (early_q & line_q) | (mid_q & line_q);
  assign bit_end      = (cnt_q == CntLast);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: framing FSM with parity, framing and break reporting.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           i_Clock,
  input  logic           i_Rst_n,
  input  logic           i_Rx_Serial,
  uart_rx_cfg_if.master  rx_if
);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop_low_q, stop_low_d;
  logic                 stop_high_q, stop_high_d;

  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;

  logic line, sample_valid, vote, bit_end, clear;
  logic data_xor, par_err, is_break;

  uart_bit_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_sampler (
    .clk          (i_Clock),
    .rst_n        (i_Rst_n),
    .rx_serial    (i_Rx_Serial),
    .clear        (clear),
    .line         (line),
    .sample_valid (sample_valid),
    .vote         (vote),
    .bit_end      (bit_end)
  );

  assign data_xor = (^shift_q) ^ par_bit_q;
  assign par_err  = (PARITY == PAR_EVEN) ? data_xor :
                    (PARITY == PAR_ODD)  ? ~data_xor : 1'b0;
  assign is_break = (shift_q == '0) && !par_bit_q && !stop_high_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    par_bit_d   = par_bit_q;
    stop_low_d  = stop_low_q;
    stop_high_d = stop_high_q;
    dv_d        = 1'b0;
    data_d      = data_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    brk_d       = brk_q;
    clear       = 1'b0;

    unique case (state_q)
      StIdle: begin
        clear = 1'b1;
        if (!line) begin
          state_d     = StStart;
          shift_d     = '0;
          bit_idx_d   = '0;
          stop_idx_d  = 1'b0;
          par_bit_d   = 1'b0;
          stop_low_d  = 1'b0;
          stop_high_d = 1'b0;
        end
      end
      StStart: begin
        if (sample_valid && vote) begin
          state_d = StIdle;
        end else if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (sample_valid) begin
          shift_d   = {vote, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 4'd1;
        end
        if (bit_end && (bit_idx_q == 4'(DATA_BITS))) begin
          state_d = (PARITY != PAR_NONE) ? StParity : StStop;
        end
      end
      StParity: begin
        if (sample_valid) par_bit_d = vote;
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        // Leave right after the last vote so a following start edge is never missed.
        if (sample_valid) begin
          if (vote) stop_high_d = 1'b1;
          else      stop_low_d  = 1'b1;
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            state_d = StDone;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      StDone: begin
        clear   = 1'b1;
        dv_d    = 1'b1;
        data_d  = shift_q;
        perr_d  = par_err;
        ferr_d  = stop_low_q;
        brk_d   = is_break;
        state_d = is_break ? StBreakWait : StIdle;
      end
      StBreakWait: begin
        // Counter only survives while the line stays high, so bit_end means a full high bit.
        clear = !line;
        if (line && bit_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      par_bit_q   <= 1'b0;
      stop_low_q  <= 1'b0;
      stop_high_q <= 1'b0;
      dv_q        <= 1'b0;
      data_q      <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      par_bit_q   <= par_bit_d;
      stop_low_q  <= stop_low_d;
      stop_high_q <= stop_high_d;
      dv_q        <= dv_d;
      data_q      <= data_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      brk_q       <= brk_d;
    end
  end

  assign rx_if.o_Rx_DV      = dv_q;
  assign rx_if.o_Rx_Byte    = data_q;
  assign rx_if.o_Parity_Err = perr_q;
  assign rx_if.o_Frame_Err  = ferr_q;
  assign rx_if.o_Break      = brk_q;
  assign rx_if.o_Rx_Busy    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for three receiver configurations: 8N1, 8E1 and 9O2.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic rx_a  = 1'b1;
  logic rx_b  = 1'b1;
  logic rx_c  = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int dv_b     = 0;
  int dv_c     = 0;
  logic [7:0] q_a[$];

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if_b ();
  uart_rx_cfg_if #(.DATA_BITS(9)) if_c ();

  uart_rx_cfg #(.CLKS_PER_BIT(87), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) dut_a (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_a), .rx_if(if_a)
  );
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_b (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_b), .rx_if(if_b)
  );
  uart_rx_cfg #(.CLKS_PER_BIT(8), .DATA_BITS(9), .PARITY(PAR_ODD), .STOP_BITS(2)) dut_c (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_c), .rx_if(if_c)
  );

  always @(negedge clk) begin
    if (if_a.o_Rx_DV) q_a.push_back(if_a.o_Rx_Byte);
    if (if_b.o_Rx_DV) dv_b <= dv_b + 1;
    if (if_c.o_Rx_DV) dv_c <= dv_c + 1;
  end

  function automatic int clks(input int sel);
    return (sel == 0) ? 87 : (sel == 1) ? 16 : 8;
  endfunction
  function automatic int nbits(input int sel);
    return (sel == 2) ? 9 : 8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v);
    case (sel)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_bits(input int sel, input int n);
    wait_cycles(n * clks(sel));
  endtask

  // glitch >= 0 flips the line for one clock inside the vote window of that data bit.
  task automatic send_frame(input int sel, input logic [8:0] data, input logic par,
                            input logic s1, input logic s2, input int glitch);
    int c;
    c = clks(sel);
    drive(sel, 1'b0);
    wait_bits(sel, 1);
    for (int i = 0; i < nbits(sel); i++) begin
      drive(sel, data[i]);
      if (i == glitch) begin
        wait_cycles(c / 2 + 2);
        drive(sel, ~data[i]);
        wait_cycles(1);
        drive(sel, data[i]);
        wait_cycles(c - c / 2 - 3);
      end else begin
        wait_bits(sel, 1);
      end
    end
    if (sel != 0) begin
      drive(sel, par);
      wait_bits(sel, 1);
    end
    drive(sel, s1);
    wait_bits(sel, 1);
    if (sel == 2) begin
      drive(sel, s2);
      wait_bits(sel, 1);
    end
    drive(sel, 1'b1);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    wait_cycles(4);
    chk("reset_dv",    {31'd0, if_a.o_Rx_DV},        32'd0);
    chk("reset_byte",  {24'd0, if_a.o_Rx_Byte},      32'd0);
    chk("reset_flags", {29'd0, if_a.o_Parity_Err, if_a.o_Frame_Err, if_a.o_Break}, 32'd0);
    chk("reset_busy",  {31'd0, if_a.o_Rx_Busy},      32'd0);
    chk("reset_byte_c", {23'd0, if_c.o_Rx_Byte},     32'd0);
    rst_n = 1'b1;
    wait_cycles(5);

    // 8N1 back-to-back frames
    send_frame(0, 9'h03F, 1'b0, 1'b1, 1'b1, -1);
    send_frame(0, 9'h0AB, 1'b0, 1'b1, 1'b1, -1);
    wait_bits(0, 2);
    chk("b2b_count",  q_a.size(), 32'd2);
    chk("b2b_first",  {24'd0, q_a[0]}, 32'h3F);
    chk("b2b_second", {24'd0, q_a[1]}, 32'hAB);
    chk("b2b_flags",  {29'd0, if_a.o_Parity_Err, if_a.o_Frame_Err, if_a.o_Break}, 32'd0);

    // Even parity: 0xA5 has four ones, so the correct parity bit is 0
    send_frame(1, 9'h0A5, 1'b1, 1'b1, 1'b1, -1);
    wait_bits(1, 2);
    chk("even_bad_dv",   dv_b, 32'd1);
    chk("even_bad_byte", {24'd0, if_b.o_Rx_Byte}, 32'hA5);
    chk("even_bad_perr", {31'd0, if_b.o_Parity_Err}, 32'd1);
    send_frame(1, 9'h0A5, 1'b0, 1'b1, 1'b1, -1);
    wait_bits(1, 2);
    chk("even_ok_dv",   dv_b, 32'd2);
    chk("even_ok_perr", {31'd0, if_b.o_Parity_Err}, 32'd0);
    chk("even_ok_ferr", {31'd0, if_b.o_Frame_Err}, 32'd0);

    // False start: 20 clocks low is far shorter than the mid-bit vote point
    rx_a = 1'b0;
    wait_cycles(10);
    chk("fs_busy_hi", {31'd0, if_a.o_Rx_Busy}, 32'd1);
    wait_cycles(10);
    rx_a = 1'b1;
    wait_bits(0, 2);
    chk("fs_no_dv",   q_a.size(), 32'd2);
    chk("fs_busy_lo", {31'd0, if_a.o_Rx_Busy}, 32'd0);

    // Single-clock glitch inside the vote window of data bit 2
    send_frame(0, 9'h055, 1'b0, 1'b1, 1'b1, 2);
    wait_bits(0, 2);
    chk("glitch_count", q_a.size(), 32'd3);
    chk("glitch_byte",  {24'd0, q_a[2]}, 32'h55);

    // Stop bit low with non-zero data: framing error only
    send_frame(0, 9'h03F, 1'b0, 1'b0, 1'b0, -1);
    wait_bits(0, 2);
    chk("frame_count", q_a.size(), 32'd4);
    chk("frame_byte",  {24'd0, q_a[3]}, 32'h3F);
    chk("frame_ferr",  {31'd0, if_a.o_Frame_Err}, 32'd1);
    chk("frame_brk",   {31'd0, if_a.o_Break}, 32'd0);
    chk("frame_busy",  {31'd0, if_a.o_Rx_Busy}, 32'd0);

    // Break: line low for 15 bit times
    rx_a = 1'b0;
    wait_bits(0, 15);
    chk("brk_count", q_a.size(), 32'd5);
    chk("brk_byte",  {24'd0, q_a[4]}, 32'h00);
    chk("brk_flag",  {31'd0, if_a.o_Break}, 32'd1);
    chk("brk_ferr",  {31'd0, if_a.o_Frame_Err}, 32'd1);
    chk("brk_wait",  {31'd0, if_a.o_Rx_Busy}, 32'd1);
    rx_a = 1'b1;
    wait_cycles(40);
    chk("brk_hold",  {31'd0, if_a.o_Rx_Busy}, 32'd1);
    wait_bits(0, 2);
    chk("brk_idle",  {31'd0, if_a.o_Rx_Busy}, 32'd0);
    chk("brk_one_dv", q_a.size(), 32'd5);
    send_frame(0, 9'h03F, 1'b0, 1'b1, 1'b1, -1);
    wait_bits(0, 2);
    chk("post_brk_byte",  {24'd0, q_a[5]}, 32'h3F);
    chk("post_brk_flags", {29'd0, if_a.o_Parity_Err, if_a.o_Frame_Err, if_a.o_Break}, 32'd0);

    // 9O2: 0x1AB has six ones, odd parity bit 1; second stop bit low
    send_frame(2, 9'h1AB, 1'b1, 1'b1, 1'b0, -1);
    wait_bits(2, 3);
    chk("c_dv",   dv_c, 32'd1);
    chk("c_byte", {23'd0, if_c.o_Rx_Byte}, 32'h1AB);
    chk("c_perr", {31'd0, if_c.o_Parity_Err}, 32'd0);
    chk("c_ferr", {31'd0, if_c.o_Frame_Err}, 32'd1);
    chk("c_brk",  {31'd0, if_c.o_Break}, 32'd0);
    // Zero data with parity bit 1 is not a break
    send_frame(2, 9'h000, 1'b1, 1'b1, 1'b1, -1);
    wait_bits(2, 3);
    chk("c0_dv",    dv_c, 32'd2);
    chk("c0_flags", {29'd0, if_c.o_Parity_Err, if_c.o_Frame_Err, if_c.o_Break}, 32'd0);

    // Reset during data bit 4 of a partial all-ones frame
    rx_a = 1'b0;
    wait_bits(0, 1);
    rx_a = 1'b1;
    wait_bits(0, 4);
    wait_cycles(43);
    chk("pre_rst_busy", {31'd0, if_a.o_Rx_Busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_busy", {31'd0, if_a.o_Rx_Busy}, 32'd0);
    chk("rst_async_byte", {24'd0, if_a.o_Rx_Byte}, 32'd0);
    chk("rst_async_b",    {24'd0, if_b.o_Rx_Byte}, 32'd0);
    chk("rst_async_c",    {30'd0, if_c.o_Frame_Err, if_c.o_Rx_DV}, 32'd0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_bits(0, 1);
    chk("rst_no_dv", q_a.size(), 32'd6);
    send_frame(0, 9'h0C3, 1'b0, 1'b1, 1'b1, -1);
    wait_bits(0, 2);
    chk("rst_count", q_a.size(), 32'd7);
    chk("rst_byte",  {24'd0, q_a[6]}, 32'hC3);
    chk("rst_flags", {29'd0, if_a.o_Parity_Err, if_a.o_Frame_Err, if_a.o_Break}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
